// File: rtl/rpw_sequencer.sv
// Read/process/write job sequencer with phase watchdog, bounded retry, abort and latched error code.
// Outputs are registered from next state. Optional job cycle counter under RPW_SEQ_PERF_EN.
module rpw_sequencer #(
   parameter int TIMEOUT_W = 16,
   parameter int MAX_RETRY = 3,
   parameter int RETRY_W   = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 write_only,
   input  logic [TIMEOUT_W-1:0] timeout_cycles,
   input  logic                 data_read_complete,
   input  logic                 processing_complete,
   input  logic                 write_complete,
   input  logic                 error,
   input  logic                 abort,
   input  logic                 clear_error,
   output logic [2:0]           state,
   output logic                 read_data,
   output logic                 process_data,
   output logic                 write_data,
   output logic                 handle_error,
   output logic                 busy,
   output logic                 done,
   output logic [1:0]           err_code,
   output logic [RETRY_W-1:0]   retry_count
`ifdef RPW_SEQ_PERF_EN
   ,
   output logic [31:0]          job_cycles
`endif
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'b000,
      S_READ    = 3'b001,
      S_PROCESS = 3'b010,
      S_WRITE   = 3'b011,
      S_ERROR   = 3'b100,
      S_RETRY   = 3'b101
   } state_e;

   localparam logic [1:0]           ERR_NONE    = 2'b00;
   localparam logic [1:0]           ERR_INPUT   = 2'b01;
   localparam logic [1:0]           ERR_TIMEOUT = 2'b10;
   localparam logic [TIMEOUT_W-1:0] WD_ONE      = 1;
   localparam logic [RETRY_W-1:0]   RETRY_ONE   = 1;
   localparam logic [RETRY_W-1:0]   MAX_RETRY_L = RETRY_W'(MAX_RETRY);

   state_e               state_q, state_d;
   logic                 wo_q, wo_d;
   logic [1:0]           err_q, err_d;
   logic [RETRY_W-1:0]   retry_q, retry_d;
   logic [TIMEOUT_W-1:0] wd_q, wd_d;
   logic                 done_q, done_d;
   logic                 rd_q, pr_q, wr_q, herr_q, busy_q;
   logic                 phase_cmp;
   logic                 timeout_hit;

   // wd_q counts cycles already spent in the phase, so the Nth cycle sees N-1.
   assign timeout_hit = (timeout_cycles != '0) && (wd_q >= (timeout_cycles - WD_ONE));

   always_comb begin
      state_d   = state_q;
      wo_d      = wo_q;
      err_d     = err_q;
      retry_d   = retry_q;
      wd_d      = '0;
      done_d    = 1'b0;
      phase_cmp = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               wo_d    = write_only;
               err_d   = ERR_NONE;
               retry_d = '0;
               state_d = write_only ? S_WRITE : S_READ;
            end
         end
         S_READ, S_PROCESS, S_WRITE: begin
            if (state_q == S_READ)         phase_cmp = data_read_complete;
            else if (state_q == S_PROCESS) phase_cmp = processing_complete;
            else                           phase_cmp = write_complete;

            if (abort) begin
               state_d = S_IDLE;
               retry_d = '0;
            end else if (phase_cmp) begin
               if (state_q == S_WRITE) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = (state_q == S_READ) ? S_PROCESS : S_WRITE;
               end
            end else if (error || timeout_hit) begin
               err_d = error ? ERR_INPUT : ERR_TIMEOUT;
               if (retry_q < MAX_RETRY_L) begin
                  retry_d = retry_q + RETRY_ONE;
                  state_d = S_RETRY;
               end else begin
                  state_d = S_ERROR;
               end
            end else begin
               wd_d = (wd_q == '1) ? wd_q : wd_q + WD_ONE;
            end
         end
         S_RETRY: state_d = wo_q ? S_WRITE : S_READ;
         S_ERROR: begin
            if (clear_error) begin
               state_d = S_IDLE;
               err_d   = ERR_NONE;
               retry_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         wo_q    <= 1'b0;
         err_q   <= ERR_NONE;
         retry_q <= '0;
         wd_q    <= '0;
         done_q  <= 1'b0;
         rd_q    <= 1'b0;
         pr_q    <= 1'b0;
         wr_q    <= 1'b0;
         herr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wo_q    <= wo_d;
         err_q   <= err_d;
         retry_q <= retry_d;
         wd_q    <= wd_d;
         done_q  <= done_d;
         rd_q    <= (state_d == S_READ);
         pr_q    <= (state_d == S_PROCESS);
         wr_q    <= (state_d == S_WRITE);
         herr_q  <= (state_d == S_ERROR);
         busy_q  <= (state_d != S_IDLE);
      end
   end

   assign state        = state_q;
   assign read_data    = rd_q;
   assign process_data = pr_q;
   assign write_data   = wr_q;
   assign handle_error = herr_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err_code     = err_q;
   assign retry_count  = retry_q;

`ifdef RPW_SEQ_PERF_EN
   logic [31:0] run_q;
   logic [31:0] job_q;
   logic [32:0] run_inc;
   logic [32:0] run_fin;

   // run_q already includes the acceptance cycle; the final WRITE and done cycles add two.
   assign run_inc = {1'b0, run_q} + 33'd1;
   assign run_fin = {1'b0, run_q} + 33'd2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run_q <= '0;
         job_q <= '0;
      end else begin
         if (state_q == S_IDLE && start) begin
            run_q <= 32'd1;
         end else if (state_q != S_IDLE) begin
            run_q <= run_inc[32] ? '1 : run_inc[31:0];
         end
         if (done_d) begin
            job_q <= run_fin[32] ? '1 : run_fin[31:0];
         end
      end
   end

   assign job_cycles = job_q;
`endif

endmodule

// File: doc/rpw_sequencer.md
Name: rpw_sequencer

Overview:
Parametrised read/process/write job sequencer that drives the datapath strobes for one transfer at a time. It adds several things to the plain phase FSM: per-phase watchdog timeout, bounded automatic retry on fault, an abort path, a start/busy/done handshake and a latched error code. It sits between the command front-end and the read, process and write engines, and is one instance per channel.

Parameters:
TIMEOUT_W, 16, width of the timeout_cycles input and of the internal phase watchdog counter
MAX_RETRY, 3, number of automatic retries after a fault before entering ERROR; 0 means no retry
RETRY_W, 2, width of retry_count; must satisfy 2**RETRY_W > MAX_RETRY

Ports:
clk  input  1  single clock; all state changes on its rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  job request; sampled only in IDLE
write_only  input  1  sampled with start; 1 means the job skips READ and PROCESS
timeout_cycles  input  TIMEOUT_W  phase watchdog limit; 0 disables the watchdog
data_read_complete  input  1  read engine finished
processing_complete  input  1  process engine finished
write_complete  input  1  write engine finished
error  input  1  engine fault, valid in READ, PROCESS and WRITE
abort  input  1  cancel the job in progress
clear_error  input  1  leave ERROR
state  output  3  current state encoding
read_data  output  1  high while in READ
process_data  output  1  high while in PROCESS
write_data  output  1  high while in WRITE
handle_error  output  1  high while in ERROR
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on successful job completion
err_code  output  2  00 none, 01 error input, 10 timeout
retry_count  output  RETRY_W  retries consumed by the current job

Behaviour:
- The clock is clk. Reset is asynchronous and active-high on reset.
- Reset values: state=IDLE, every strobe=0, busy=0, done=0, err_code=00, retry_count=0, watchdog=0, write_only latch=0.
- State encoding: IDLE 000, READ 001, PROCESS 010, WRITE 011, ERROR 100, RETRY 101.
- All outputs are registered and decoded from next_state. A strobe is therefore high in exactly the cycles in which state equals its phase, with no one-cycle lag.
- IDLE:
  - start=1 latches write_only, clears err_code and retry_count, then goes to WRITE if write_only=1, otherwise READ.
  - start while busy=1 is ignored.
- Phase exit priority in READ, PROCESS and WRITE, highest first: abort, then the phase's complete input, then error, then timeout.
- On complete:
  - READ goes to PROCESS.
  - PROCESS goes to WRITE.
  - WRITE goes to IDLE and pulses done=1 in the first IDLE cycle.
- abort goes to IDLE in one cycle. No done pulse. err_code is unchanged and retry_count is cleared.
- Watchdog:
  - Cleared on every phase entry; increments each cycle in a phase.
  - With timeout_cycles=N (N>0), if no complete arrives in the Nth cycle of the phase, a timeout fault is raised at the end of that cycle.
  - A complete arriving in that same cycle wins.
- Fault (error input or timeout):
  - err_code is set to 01 or 10 respectively and holds the most recent fault.
  - If retry_count < MAX_RETRY: go to RETRY for exactly one cycle with all strobes low and busy=1, increment retry_count, then restart at READ (or WRITE if the latched write_only=1).
  - Otherwise go to ERROR.
- ERROR: handle_error=1 and err_code holds. clear_error goes to IDLE and clears err_code and retry_count. Nothing else exits ERROR except reset.
- An illegal state encoding goes to IDLE on the next cycle.
- Reset asserted mid-job returns to IDLE immediately (asynchronously), with no done pulse.

Optional Feature:
Macro RPW_SEQ_PERF_EN.
- Defined: adds output job_cycles [31:0], the count of cycles from start acceptance to the done pulse inclusive, including retry cycles. It is latched when done pulses, reset to 0, and saturates at all-ones.
- Undefined: the port and its counter are absent, and all other behaviour is identical.

Test Plan:
1. Full job: start=1 with write_only=0, each complete asserted 2 cycles after its phase entry -> state sequence READ, PROCESS, WRITE, IDLE; done pulses for exactly 1 cycle; err_code=00.
2. Write-only job: start=1 with write_only=1 -> WRITE on the next cycle; read_data and process_data stay 0 throughout; write_complete -> done.
3. Timeout: timeout_cycles=4, no completes, MAX_RETRY=3 -> READ 4 cycles then RETRY, repeated 3 times (retry_count goes to 3), then ERROR with err_code=10 and handle_error=1; clear_error -> IDLE with err_code=00.
4. Simultaneous events: in PROCESS, processing_complete=1 and error=1 together -> WRITE. In WRITE, abort=1 and write_complete=1 together -> IDLE with no done pulse.
5. Error retry recovers: error pulsed once in PROCESS -> RETRY, then READ with retry_count=1 and err_code=01; the job then completes with done=1.
6. Reset mid-WRITE: reset asserted asynchronously -> all outputs 0 and state=000 before the next clk edge; start held during a job is ignored.
